// File: rtl/jt12_timer_ctrl.sv
// jt12_timer_ctrl: host register front end for the FM timer pair.
// Decodes part-I registers 0x24-0x27, drives timer reload values, load/enable
// bits, one-clk flag-clear pulses and ch3 mode, and maintains the write-busy
// flag plus the host status byte.
// Optional feature macro: JT12_BUSY_DROP_EN -- when defined, data writes that
// arrive while the busy counter is nonzero are discarded (real-chip lost-write
// behaviour); when undefined every data write is accepted and busy is status only.
module jt12_timer_ctrl #(
    parameter int BUSY_CYCLES = 32,
    parameter int BW          = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [7:0]  din,
    input  logic        flag_A,
    input  logic        flag_B,
    output logic [9:0]  value_A,
    output logic [7:0]  value_B,
    output logic        load_A,
    output logic        load_B,
    output logic        enable_irq_A,
    output logic        enable_irq_B,
    output logic        clr_flag_A,
    output logic        clr_flag_B,
    output logic [1:0]  ch3_mode,
    output logic        busy,
    output logic [7:0]  dout
);

    localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES);
    localparam logic [BW-1:0] CNT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] CNT_ONE   = {{(BW-1){1'b0}}, 1'b1};

    logic [7:0]    reg_addr_r;
    logic          part_r;
    logic [BW-1:0] busy_cnt_r;
    logic [BW-1:0] busy_cnt_nxt_s;
    logic          addr_wr_s;
    logic          data_wr_s;
    logic          accept_s;
    logic          timer_wr_s;
    logic [3:0]    reg_hit_s;
    logic [3:0]    reg_wr_s;

    // Classify the host strobe and decide whether a data write is taken.
    always_comb begin
        addr_wr_s = wr & ~addr[0];
        data_wr_s = wr & addr[0];
`ifdef JT12_BUSY_DROP_EN
        // A write on the edge the counter reaches zero still sees the old count.
        accept_s  = data_wr_s & (busy_cnt_r == CNT_ZERO);
`else
        accept_s  = data_wr_s;
`endif
        // Only part I owns the timer registers.
        timer_wr_s = accept_s & ~part_r;
    end

    // One-hot decode of the latched register address onto the four timer registers.
    always_comb begin
        reg_hit_s = 4'b0000;
        case (reg_addr_r)
            8'h24:   reg_hit_s = 4'b0001;
            8'h25:   reg_hit_s = 4'b0010;
            8'h26:   reg_hit_s = 4'b0100;
            8'h27:   reg_hit_s = 4'b1000;
            default: reg_hit_s = 4'b0000;
        endcase
        reg_wr_s = reg_hit_s & {4{timer_wr_s}};
    end

    // Busy counter next value: reload on an accepted write, else count down on cen.
    always_comb begin
        busy_cnt_nxt_s = busy_cnt_r;
        if (accept_s) begin
            busy_cnt_nxt_s = BUSY_LOAD;
        end else if (cen && (busy_cnt_r != CNT_ZERO)) begin
            busy_cnt_nxt_s = busy_cnt_r - CNT_ONE;
        end else begin
            busy_cnt_nxt_s = busy_cnt_r;
        end
    end

    // Address latch: every address write is taken, busy or not, and persists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_addr_r <= 8'h00;
            part_r     <= 1'b0;
        end else if (addr_wr_s) begin
            reg_addr_r <= din;
            part_r     <= addr[1];
        end
    end

    // Busy countdown and its registered flag, kept equal to (busy_cnt != 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt_r <= CNT_ZERO;
            busy       <= 1'b0;
        end else begin
            busy_cnt_r <= busy_cnt_nxt_s;
            busy       <= (busy_cnt_nxt_s != CNT_ZERO);
        end
    end

    // Timer reload values and the 0x27 control bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_A      <= 10'd0;
            value_B      <= 8'd0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            ch3_mode     <= 2'b00;
        end else begin
            if (reg_wr_s[0]) begin
                value_A[9:2] <= din;
            end
            if (reg_wr_s[1]) begin
                value_A[1:0] <= din[1:0];
            end
            if (reg_wr_s[2]) begin
                value_B <= din;
            end
            if (reg_wr_s[3]) begin
                load_A       <= din[0];
                load_B       <= din[1];
                enable_irq_A <= din[2];
                enable_irq_B <= din[3];
                ch3_mode     <= din[7:6];
            end
        end
    end

    // Flag-clear strobes: high for exactly the clk after a 0x27 write requesting them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
        end else begin
            clr_flag_A <= reg_wr_s[3] & din[4];
            clr_flag_B <= reg_wr_s[3] & din[5];
        end
    end

    // Host status byte, resampled every clk from the current busy and timer flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 8'h00;
        end else begin
            dout <= {busy, 5'b00000, flag_B, flag_A};
        end
    end

endmodule

// File: tb/tb_jt12_timer_ctrl.sv
// Directed bench for jt12_timer_ctrl with hand-computed expectations.
// Covers both builds of JT12_BUSY_DROP_EN where expectations differ.
module tb_jt12_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       cen;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] din;
    logic       flag_A;
    logic       flag_B;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A;
    logic       load_B;
    logic       enable_irq_A;
    logic       enable_irq_B;
    logic       clr_flag_A;
    logic       clr_flag_B;
    logic [1:0] ch3_mode;
    logic       busy;
    logic [7:0] dout;

    int total;
    int bad;
    logic cen_div4;
    int   phase;

    jt12_timer_ctrl #(.BUSY_CYCLES(32), .BW(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .cen          (cen),
        .wr           (wr),
        .addr         (addr),
        .din          (din),
        .flag_A       (flag_A),
        .flag_B       (flag_B),
        .value_A      (value_A),
        .value_B      (value_B),
        .load_A       (load_A),
        .load_B       (load_B),
        .enable_irq_A (enable_irq_A),
        .enable_irq_B (enable_irq_B),
        .clr_flag_A   (clr_flag_A),
        .clr_flag_B   (clr_flag_B),
        .ch3_mode     (ch3_mode),
        .busy         (busy),
        .dout         (dout)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cen generator: always high, or high one clk in four; updated just after posedge.
    initial begin
        cen   = 1'b1;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cen_div4) begin
                phase = (phase + 1) % 4;
                cen   = (phase == 0);
            end else begin
                cen = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling posedge.
    task automatic wr_addr(input logic a1, input logic [7:0] a);
        wr   = 1'b1;
        addr = {a1, 1'b0};
        din  = a;
        @(negedge clk);
        wr   = 1'b0;
    endtask

    task automatic wr_data(input logic a1, input logic [7:0] d);
        wr   = 1'b1;
        addr = {a1, 1'b1};
        din  = d;
        @(negedge clk);
        wr   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        int clks;
        int ticks;
        total    = 0;
        bad      = 0;
        cen_div4 = 1'b0;
        rst      = 1'b1;
        wr       = 1'b0;
        addr     = 2'b00;
        din      = 8'h00;
        flag_A   = 1'b0;
        flag_B   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_value_A", {6'd0, value_A}, 16'h0000);
        chk("rst_value_B", {8'd0, value_B}, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_dout", {8'd0, dout}, 16'h0000);
        chk("rst_ch3", {14'd0, ch3_mode}, 16'd0);
        chk("rst_loads", {14'd0, load_B, load_A}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Timer A reload split across 0x24/0x25
        wr_addr(1'b0, 8'h24);
        chk("t2_addr_no_busy", {15'd0, busy}, 16'd0);
        wr_data(1'b0, 8'hAB);
        chk("t2_value_A_hi", {6'd0, value_A}, 16'h02AC);
        chk("t2_busy_set", {15'd0, busy}, 16'd1);
`ifdef JT12_BUSY_DROP_EN
        wait_idle();
`endif
        wr_addr(1'b0, 8'h25);
        wr_data(1'b0, 8'hFF);
        chk("t2_value_A", {6'd0, value_A}, 16'h02AF);
        chk("t2_busy_after", {15'd0, busy}, 16'd1);

        // Control register 0x27
        wait_idle();
        wr_addr(1'b0, 8'h27);
        wr_data(1'b0, 8'h3F);
        chk("t3_loads", {14'd0, load_B, load_A}, 16'h0003);
        chk("t3_enables", {14'd0, enable_irq_B, enable_irq_A}, 16'h0003);
        chk("t3_clr_pulse", {14'd0, clr_flag_B, clr_flag_A}, 16'h0003);
        chk("t3_ch3", {14'd0, ch3_mode}, 16'd0);
        @(negedge clk);
        chk("t3_clr_end", {14'd0, clr_flag_B, clr_flag_A}, 16'h0000);
        chk("t3_loads_hold", {14'd0, load_B, load_A}, 16'h0003);
        wait_idle();
        wr_data(1'b0, 8'h80);
        chk("t3_ch3_csm", {14'd0, ch3_mode}, 16'h0002);
        chk("t3_loads_drop", {14'd0, load_B, load_A}, 16'h0000);
        chk("t3_enables_drop", {14'd0, enable_irq_B, enable_irq_A}, 16'h0000);
        chk("t3_no_clr", {14'd0, clr_flag_B, clr_flag_A}, 16'h0000);
`ifndef JT12_BUSY_DROP_EN
        wr_data(1'b0, 8'h10);
        chk("t3_b2b_first", {14'd0, clr_flag_B, clr_flag_A}, 16'h0001);
        wr_data(1'b0, 8'h20);
        chk("t3_b2b_second", {14'd0, clr_flag_B, clr_flag_A}, 16'h0002);
        chk("t3_b2b_ch3", {14'd0, ch3_mode}, 16'h0000);
        @(negedge clk);
        chk("t3_b2b_end", {14'd0, clr_flag_B, clr_flag_A}, 16'h0000);
`endif

        // Busy countdown with cen every 4th clk; address 0x30 is not a timer register
        wait_idle();
        cen_div4 = 1'b1;
        wr_addr(1'b0, 8'h30);
        wr_data(1'b0, 8'h00);
        chk("t4_busy_set", {15'd0, busy}, 16'd1);
        chk("t4_dout_lag", {8'd0, dout}, 16'h0000);
        chk("t4_ignored_addr", {6'd0, value_A}, 16'h02AF);
        clks  = 0;
        ticks = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            clks++;
            if (cen) ticks++;
            @(negedge clk);
        end
        chk("t4_busy_cleared", {15'd0, busy}, 16'd0);
        chk("t4_cen_ticks", 16'(ticks), 16'd32);
        chk("t4_clk_range", {15'd0, (clks >= 125 && clks <= 128)}, 16'd1);
        chk("t4_dout_busy_tail", {15'd0, dout[7]}, 16'd1);
        @(negedge clk);
        chk("t4_dout_idle", {8'd0, dout}, 16'h0000);
        cen_div4 = 1'b0;

        // Data write while busy
        wait_idle();
        wr_addr(1'b0, 8'h26);
        wr_data(1'b0, 8'h11);
        wr_data(1'b0, 8'h22);
`ifdef JT12_BUSY_DROP_EN
        chk("t5_value_B", {8'd0, value_B}, 16'h0011);
`else
        chk("t5_value_B", {8'd0, value_B}, 16'h0022);
`endif
        clks = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            clks++;
            @(negedge clk);
        end
`ifdef JT12_BUSY_DROP_EN
        chk("t5_busy_len", 16'(clks), 16'd31);
`else
        chk("t5_busy_len", 16'(clks), 16'd32);
`endif

        // Part II write: no timer update, busy still set; status byte
        wait_idle();
        flag_A = 1'b1;
        wr_addr(1'b1, 8'h24);
        wr_data(1'b1, 8'h55);
        chk("t6_value_A_kept", {6'd0, value_A}, 16'h02AF);
        chk("t6_busy", {15'd0, busy}, 16'd1);
        chk("t6_dout_first", {8'd0, dout}, 16'h0001);
        @(negedge clk);
        chk("t6_dout_busy", {8'd0, dout}, 16'h0081);
        flag_B = 1'b1;
        @(negedge clk);
        chk("t6_dout_both", {8'd0, dout}, 16'h0083);

        // Asynchronous reset mid-countdown
        flag_A = 1'b0;
        flag_B = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t1_busy_async", {15'd0, busy}, 16'd0);
        chk("t1_dout_async", {8'd0, dout}, 16'h0000);
        chk("t1_value_A_async", {6'd0, value_A}, 16'h0000);
        chk("t1_value_B_async", {8'd0, value_B}, 16'h0000);
        chk("t1_ch3_async", {14'd0, ch3_mode}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_dout_next", {8'd0, dout}, 16'h0000);
        chk("t1_busy_next", {15'd0, busy}, 16'd0);
        // Address latch reset to 0x00: a data write touches no timer register
        wr_data(1'b0, 8'h99);
        chk("t1_addr_rst_A", {6'd0, value_A}, 16'h0000);
        chk("t1_addr_rst_B", {8'd0, value_B}, 16'h0000);
        chk("t1_addr_rst_busy", {15'd0, busy}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
